// File: rtl/filling_pkg.sv
// Shared constants and helpers for the filling-time BCD counter.
// Provides digit width, digit maximum, direction encodings and a decimal-to-BCD converter.
package filling_pkg;

    localparam int BCD_W = 4;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic COUNT_UP = 1'b1;
    localparam logic COUNT_DOWN = 1'b0;

    // Converts a decimal value (up to four digits) to packed BCD, digit 0 in bits [3:0].
    function automatic logic [15:0] to_bcd(input int value);
        logic [15:0] bcd;
        int v;
        bcd = 16'h0000;
        v = value;
        for (int i = 0; i < 4; i++) begin
            bcd[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/filling_bcd_counter_digit.sv
// One BCD digit of the filling counter: holds its digit and ripples carry/borrow.
// Load and step decisions come from the top level; this cell only applies them.
module bcd_digit_cell
    import filling_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             dir,
    input  logic             cin,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_digit,
    output logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] digit_nxt,
    output logic             cout
);

    logic [BCD_W-1:0] digit_r;

    // Next digit: load wins, otherwise step only when the lower digits carry/borrow in.
    always_comb begin
        digit_nxt = digit_r;
        cout      = 1'b0;
        if (ld) begin
            digit_nxt = ld_digit;
        end else if (step && cin) begin
            if (dir == COUNT_UP) begin
                if (digit_r >= DIGIT_MAX) begin
                    digit_nxt = 4'd0;
                    cout      = 1'b1;
                end else begin
                    digit_nxt = digit_r + 4'd1;
                end
            end else begin
                if (digit_r == 4'd0) begin
                    digit_nxt = DIGIT_MAX;
                    cout      = 1'b1;
                end else begin
                    digit_nxt = digit_r - 4'd1;
                end
            end
        end else begin
            digit_nxt = digit_r;
        end
    end

    // Digit register, cleared by the shared asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_r <= 4'd0;
        end else begin
            digit_r <= digit_nxt;
        end
    end

    assign digit = digit_r;

endmodule

// File: rtl/filling_bcd_counter.sv
// Multi-digit BCD counter for the filling-time path with load, up/down,
// wrap or saturate at the limits, and registered limit / terminal-count flags.
module filling_bcd_counter
    import filling_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int MAX_COUNT = 99,
    parameter int WRAP      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  at_max,
    output logic                  at_zero,
    output logic                  tc
);

    localparam int CW = BCD_W * DIGITS;
    localparam logic [15:0] MAX_BCD16 = to_bcd(MAX_COUNT);
    localparam logic [CW-1:0] MAX_BCD = MAX_BCD16[CW-1:0];
    localparam logic AT_MAX_RST = (MAX_COUNT == 0) ? 1'b1 : 1'b0;

    logic [CW-1:0] count_s;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] clamp_s;
    logic [CW-1:0] ld_val_s;
    logic [DIGITS:0] carry_s;
    logic          carry_unused_s;
    logic          step_s;
    logic          ld_s;
    logic          tc_nxt_s;
    logic          at_max_r;
    logic          at_zero_r;
    logic          tc_r;

    // Clamp each incoming digit to 9 so the counter never holds an invalid BCD digit.
    always_comb begin
        clamp_s = {CW{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            clamp_s[i*BCD_W +: BCD_W] = (load_val[i*BCD_W +: BCD_W] > DIGIT_MAX) ?
                                        DIGIT_MAX : load_val[i*BCD_W +: BCD_W];
        end
    end

    // Step control; wrapping at a limit is done as a load of the opposite limit.
    always_comb begin
        step_s   = 1'b0;
        ld_s     = 1'b0;
        ld_val_s = {CW{1'b0}};
        tc_nxt_s = 1'b0;
        if (load) begin
            ld_s     = 1'b1;
            ld_val_s = (clamp_s > MAX_BCD) ? MAX_BCD : clamp_s;
        end else if (en) begin
            if ((up_dn == COUNT_UP) && (count_s == MAX_BCD)) begin
                tc_nxt_s = 1'b1;
                if (WRAP != 0) begin
                    ld_s     = 1'b1;
                    ld_val_s = {CW{1'b0}};
                end else begin
                    ld_s     = 1'b0;
                end
            end else if ((up_dn == COUNT_DOWN) && (count_s == {CW{1'b0}})) begin
                tc_nxt_s = 1'b1;
                if (WRAP != 0) begin
                    ld_s     = 1'b1;
                    ld_val_s = MAX_BCD;
                end else begin
                    ld_s     = 1'b0;
                end
            end else begin
                step_s = 1'b1;
            end
        end else begin
            step_s = 1'b0;
        end
    end

    assign carry_s[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_digit (
            .clk       (clk),
            .reset     (reset),
            .step      (step_s),
            .dir       (up_dn),
            .cin       (carry_s[g]),
            .ld        (ld_s),
            .ld_digit  (ld_val_s[g*BCD_W +: BCD_W]),
            .digit     (count_s[g*BCD_W +: BCD_W]),
            .digit_nxt (count_nxt_s[g*BCD_W +: BCD_W]),
            .cout      (carry_s[g+1])
        );
    end

    // The top digit never carries out because stepping stops at MAX_COUNT.
    assign carry_unused_s = carry_s[DIGITS];

    // Flags follow the next count so they line up with count itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            at_max_r  <= AT_MAX_RST;
            at_zero_r <= 1'b1;
            tc_r      <= 1'b0;
        end else begin
            at_max_r  <= (count_nxt_s == MAX_BCD);
            at_zero_r <= (count_nxt_s == {CW{1'b0}});
            tc_r      <= tc_nxt_s;
        end
    end

    assign count   = count_s;
    assign at_max  = at_max_r;
    assign at_zero = at_zero_r;
    assign tc      = tc_r;

endmodule
